// File: rtl/map_tile_sequencer_if.sv
// map_tile_sequencer_if: scan, sprite-ROM, tile-update and tile-query signals of the maze sequencer.
interface map_tile_sequencer_if #(parameter int PIX_W = 10, parameter int FIFO_DEPTH = 4);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [PIX_W-1:0] pix_x;
  logic [PIX_W-1:0] pix_y;
  logic             pix_valid;
  logic [4:0]       grid_select;
  logic [1:0]       rotate_select;
  logic [1:0]       mirror_select;
  logic [2:0]       x_index;
  logic [2:0]       y_index;
  logic [11:0]      map_color;
  logic [11:0]      pix_color;
  logic             pix_color_valid;
  logic             wr_req;
  logic [4:0]       wr_col;
  logic [4:0]       wr_row;
  logic [8:0]       wr_tile;
  logic             wr_ready;
  logic             q_req;
  logic [4:0]       q_col;
  logic [4:0]       q_row;
  logic             q_ack;
  logic [8:0]       q_tile;
  logic [CW-1:0]    fifo_count;
  modport master (
    output pix_x, pix_y, pix_valid, map_color, wr_req, wr_col, wr_row, wr_tile, q_req, q_col, q_row,
    input  grid_select, rotate_select, mirror_select, x_index, y_index, pix_color, pix_color_valid,
           wr_ready, q_ack, q_tile, fifo_count
  );
  modport slave (
    input  pix_x, pix_y, pix_valid, map_color, wr_req, wr_col, wr_row, wr_tile, q_req, q_col, q_row,
    output grid_select, rotate_select, mirror_select, x_index, y_index, pix_color, pix_color_valid,
           wr_ready, q_ack, q_tile, fifo_count
  );
endinterface

// File: rtl/map_tile_sequencer.sv
// map_tile_sequencer: tile-map RAM shared by display scan, buffered tile updates and tile queries.
module map_tile_sequencer #(
  parameter int MAP_COLS   = 28,
  parameter int MAP_ROWS   = 31,
  parameter int PIX_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  map_tile_sequencer_if.slave bus
);
  localparam int WORDS = MAP_COLS * MAP_ROWS;
  localparam int AW = $clog2(WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  function automatic logic [AW-1:0] addr_of(input int col, input int row);
    return AW'(row * MAP_COLS + col);
  endfunction
  function automatic logic in_map(input int col, input int row);
    return col < MAP_COLS && row < MAP_ROWS;
  endfunction
  logic [8:0]       r_mem [WORDS];
  logic [8:0]       r_dout;
  logic [18:0]      r_fifo [FIFO_DEPTH];
  logic [FW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_q_ack, r_q_oor;
  logic             r_s1_valid, r_s1_in;
  logic [2:0]       r_s1_x, r_s1_y;
  logic [11:0]      r_color;
  logic             r_color_valid;
  logic [PIX_W-4:0] w_d_col, w_d_row;
  logic [18:0]      w_head;
  logic             w_d_in, w_full, w_push, w_pop, w_q_issue, w_we, w_rd, w_show;
  logic [AW-1:0]    w_addr;
  assign w_d_col   = bus.pix_x[PIX_W-1:3];
  assign w_d_row   = bus.pix_y[PIX_W-1:3];
  assign w_d_in    = in_map(32'(w_d_col), 32'(w_d_row));
  assign w_head    = r_fifo[r_rp];
  assign w_full    = r_cnt == CW'(FIFO_DEPTH);
  assign w_push    = bus.wr_req && !w_full;
  assign w_pop     = !rst && !bus.pix_valid && r_cnt != '0;
  // queries wait for an empty FIFO so they never return data older than an accepted write
  assign w_q_issue = !rst && !bus.pix_valid && r_cnt == '0 && bus.q_req && !r_q_ack;
  assign w_we      = w_pop && in_map(32'(w_head[18:14]), 32'(w_head[13:9]));
  assign w_rd      = bus.pix_valid || w_q_issue;
  assign w_addr    = bus.pix_valid ? addr_of(32'(w_d_col), 32'(w_d_row)) :
                     w_pop ? addr_of(32'(w_head[18:14]), 32'(w_head[13:9])) :
                     addr_of(32'(bus.q_col), 32'(bus.q_row));
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_head[8:0];
    if (w_rd) r_dout <= r_mem[w_addr];
    if (w_push) r_fifo[r_wp] <= {bus.wr_col, bus.wr_row, bus.wr_tile};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
      r_q_ack       <= 1'b0;
      r_q_oor       <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_in       <= 1'b0;
      r_s1_x        <= '0;
      r_s1_y        <= '0;
      r_color       <= '0;
      r_color_valid <= 1'b0;
    end else begin
      r_wp          <= r_wp + FW'(w_push);
      r_rp          <= r_rp + FW'(w_pop);
      r_cnt         <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_q_ack       <= w_q_issue;
      r_q_oor       <= w_q_issue ? !in_map(32'(bus.q_col), 32'(bus.q_row)) : r_q_oor;
      r_s1_valid    <= bus.pix_valid;
      r_s1_in       <= w_d_in;
      r_s1_x        <= bus.pix_x[2:0];
      r_s1_y        <= bus.pix_y[2:0];
      r_color       <= r_s1_valid ? (r_s1_in ? bus.map_color : 12'h000) : r_color;
      r_color_valid <= r_s1_valid;
    end
  end
  assign w_show              = r_s1_valid && r_s1_in;
  assign bus.grid_select     = w_show ? r_dout[8:4] : '0;
  assign bus.rotate_select   = w_show ? r_dout[3:2] : '0;
  assign bus.mirror_select   = w_show ? r_dout[1:0] : '0;
  assign bus.x_index         = r_s1_x;
  assign bus.y_index         = r_s1_y;
  assign bus.pix_color       = r_color;
  assign bus.pix_color_valid = r_color_valid;
  assign bus.wr_ready        = !w_full;
  assign bus.q_ack           = r_q_ack;
  assign bus.q_tile          = (r_q_ack && !r_q_oor) ? r_dout : '0;
  assign bus.fifo_count      = r_cnt;
endmodule

// File: tb/tb_map_tile_sequencer.sv
// tb_map_tile_sequencer: directed scenarios for the tile-map sequencer with a sprite-ROM stub.
module tb_map_tile_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  map_tile_sequencer_if bus ();
  map_tile_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  // ROM stub: colour encodes the lookup controls so the colour path is checkable
  assign bus.map_color = {bus.grid_select, bus.rotate_select, bus.mirror_select, bus.x_index};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b0;
    bus.wr_req = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_tile = '0;
    bus.q_req = 1'b0; bus.q_col = '0; bus.q_row = '0;
  endtask

  task automatic do_query(input logic [4:0] c, input logic [4:0] r, input logic [8:0] exp, input string nm);
    bit got = 0;
    bus.q_col = c; bus.q_row = r; bus.q_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (bus.q_ack === 1'b1) begin got = 1; break; end
    end
    bus.q_req = 1'b0;
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL %s: no Q_ACK within 20 cycles", nm); end
    else if (bus.q_tile !== exp) begin n_bad++; $display("FAIL %s: Q_TILE got %h want %h", nm, bus.q_tile, exp); end
    tick;
    n_cmp++;
    if (bus.q_ack !== 1'b0) begin n_bad++; $display("FAIL %s_pulse: Q_ACK got %b want 0", nm, bus.q_ack); end
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1'b1;
    repeat (3) tick;
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 1", bus.wr_ready); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.q_ack !== 1'b0) begin n_bad++; $display("FAIL rst_q_ack: got %b want 0", bus.q_ack); end
    n_cmp++; if (bus.q_tile !== 9'h000) begin n_bad++; $display("FAIL rst_q_tile: got %h want 000", bus.q_tile); end
    n_cmp++; if (bus.pix_color_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pcv: got %b want 0", bus.pix_color_valid); end
    n_cmp++; if (bus.pix_color !== 12'h000) begin n_bad++; $display("FAIL rst_color: got %h want 000", bus.pix_color); end
    n_cmp++; if ({bus.grid_select, bus.rotate_select, bus.mirror_select, bus.x_index, bus.y_index} !== 15'h0)
      begin n_bad++; $display("FAIL rst_rom_ctl: got %h want 0", {bus.grid_select, bus.rotate_select, bus.mirror_select, bus.x_index, bus.y_index}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_query;
    bus.wr_col = 5'd3; bus.wr_row = 5'd2; bus.wr_tile = 9'h0A5; bus.wr_req = 1'b1;
    tick;
    bus.wr_req = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL wq_count1: got %0d want 1", bus.fifo_count); end
    tick;
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL wq_count0: got %0d want 0", bus.fifo_count); end
    do_query(5'd3, 5'd2, 9'h0A5, "wq_q32");
    do_query(5'd28, 5'd2, 9'h000, "wq_oor");
  endtask

  task automatic test_scan;
    bus.pix_x = 10'd27; bus.pix_y = 10'd18; bus.pix_valid = 1'b1;
    tick;
    bus.pix_valid = 1'b0;
    n_cmp++; if (bus.grid_select !== 5'h0A) begin n_bad++; $display("FAIL scan_grid: got %h want 0a", bus.grid_select); end
    n_cmp++; if (bus.rotate_select !== 2'b01) begin n_bad++; $display("FAIL scan_rot: got %b want 01", bus.rotate_select); end
    n_cmp++; if (bus.mirror_select !== 2'b01) begin n_bad++; $display("FAIL scan_mir: got %b want 01", bus.mirror_select); end
    n_cmp++; if (bus.x_index !== 3'd3 || bus.y_index !== 3'd2) begin n_bad++; $display("FAIL scan_idx: got %0d,%0d want 3,2", bus.x_index, bus.y_index); end
    tick;
    n_cmp++; if (bus.pix_color !== 12'h52B) begin n_bad++; $display("FAIL scan_color: got %h want 52b", bus.pix_color); end
    n_cmp++; if (bus.pix_color_valid !== 1'b1) begin n_bad++; $display("FAIL scan_pcv: got %b want 1", bus.pix_color_valid); end
    tick;
    n_cmp++; if (bus.pix_color_valid !== 1'b0 || bus.pix_color !== 12'h52B)
      begin n_bad++; $display("FAIL scan_hold: got %b/%h want 0/52b", bus.pix_color_valid, bus.pix_color); end
  endtask

  task automatic test_out_of_map;
    bus.pix_x = 10'd224; bus.pix_y = 10'd18; bus.pix_valid = 1'b1;
    tick;
    bus.pix_valid = 1'b0;
    n_cmp++; if (bus.grid_select !== 5'h00 || bus.rotate_select !== 2'b00 || bus.mirror_select !== 2'b00)
      begin n_bad++; $display("FAIL oom_rom_ctl: got %h/%b/%b want 0", bus.grid_select, bus.rotate_select, bus.mirror_select); end
    tick;
    n_cmp++; if (bus.pix_color !== 12'h000 || bus.pix_color_valid !== 1'b1)
      begin n_bad++; $display("FAIL oom_color: got %h/%b want 000/1", bus.pix_color, bus.pix_color_valid); end
  endtask

  task automatic test_fifo_full;
    logic [4:0] cols [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3};
    logic [4:0] rows [5] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd2};
    logic [8:0] tiles [5] = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h1FE};
    bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_col = cols[i]; bus.wr_row = rows[i]; bus.wr_tile = tiles[i]; bus.wr_req = 1'b1;
      tick;
      n_cmp++; if (bus.fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin n_bad++; $display("FAIL full_count%0d: got %0d want %0d", i, bus.fifo_count, (i < 4) ? i + 1 : 4); end
      n_cmp++; if (bus.wr_ready !== (i < 3)) begin n_bad++; $display("FAIL full_ready%0d: got %b want %b", i, bus.wr_ready, i < 3); end
    end
    bus.wr_req = 1'b0; bus.pix_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      tick;
      n_cmp++; if (bus.fifo_count !== 3'(i)) begin n_bad++; $display("FAIL drain%0d: got %0d want %0d", i, bus.fifo_count, i); end
    end
    do_query(5'd0, 5'd10, 9'h101, "full_q0");
    do_query(5'd1, 5'd10, 9'h102, "full_q1");
    do_query(5'd2, 5'd10, 9'h103, "full_q2");
    do_query(5'd3, 5'd10, 9'h104, "full_q3");
    do_query(5'd3, 5'd2, 9'h0A5, "full_dropped");
  endtask

  task automatic test_query_waits;
    bus.pix_valid = 1'b1;
    bus.wr_col = 5'd3; bus.wr_row = 5'd2; bus.wr_tile = 9'h1FF; bus.wr_req = 1'b1;
    tick;
    bus.wr_req = 1'b0;
    bus.q_col = 5'd3; bus.q_row = 5'd2; bus.q_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (bus.q_ack !== 1'b0 || bus.fifo_count !== 3'd1)
        begin n_bad++; $display("FAIL qw_blocked%0d: ack/count got %b/%0d want 0/1", i, bus.q_ack, bus.fifo_count); end
    end
    bus.pix_valid = 1'b0;
    do_query(5'd3, 5'd2, 9'h1FF, "qw_after_write");
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL qw_count: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_reset_mid;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_col = 5'(10 + i); bus.wr_row = 5'd10; bus.wr_tile = 9'(9'h011 * (i + 1)); bus.wr_req = 1'b1;
      tick;
    end
    bus.wr_req = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd3 || bus.pix_color_valid !== 1'b1)
      begin n_bad++; $display("FAIL mid_pre: count/pcv got %0d/%b want 3/1", bus.fifo_count, bus.pix_color_valid); end
    bus.q_col = 5'd10; bus.q_row = 5'd10; bus.q_req = 1'b1;
    rst = 1'b1;
    tick;
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", bus.wr_ready); end
    n_cmp++; if (bus.pix_color_valid !== 1'b0) begin n_bad++; $display("FAIL mid_pcv: got %b want 0", bus.pix_color_valid); end
    rst = 1'b0; bus.q_req = 1'b0; bus.pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.q_ack !== 1'b0 || bus.fifo_count !== 3'd0)
        begin n_bad++; $display("FAIL mid_quiet%0d: ack/count got %b/%0d want 0/0", i, bus.q_ack, bus.fifo_count); end
      tick;
    end
    do_query(5'd3, 5'd10, 9'h104, "mid_keep0");
    do_query(5'd3, 5'd2, 9'h1FF, "mid_keep1");
  endtask

  initial begin
    test_reset;
    test_write_query;
    test_scan;
    test_out_of_map;
    test_fifo_full;
    test_query_waits;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
